// File: rtl/sys_pkg.sv
// Shared command codes, FSM state encoding and helpers for the receive-side
// system controller.
package sys_pkg;

  localparam logic [7:0] CMD_RF_WR   = 8'hAA;
  localparam logic [7:0] CMD_RF_RD   = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam int ALU_FUN_W = 4;

  typedef enum logic [3:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_ISSUE,
    ALU_OPA,
    ALU_OPB,
    ALU_FUN_S,
    ALU_ISSUE
  } state_e;

  // States in which the controller is waiting for the next frame byte.
  function automatic logic waitsForByte(input state_e s);
    return (s == WR_ADDR) || (s == WR_DATA) || (s == RD_ADDR) ||
           (s == ALU_OPA) || (s == ALU_OPB) || (s == ALU_FUN_S);
  endfunction

endpackage

// File: rtl/sys_rx_timeout.sv
// Inter-byte timeout: counts idle cycles while a frame is in progress and
// flags expiry so the frame can be abandoned.
module sys_rx_timeout #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic active_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired_o = active_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || !active_i) begin
      cnt_d = '0;
    end else if (!expired_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sys_cntr_rx.sv
// Receive-side system controller: decodes UART command frames into register
// file and ALU strobes. Define SYS_RX_TIMEOUT_EN to abandon stalled frames.
module sys_cntr_rx
  import sys_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int OPA_ADDR       = 0,
  parameter int OPB_ADDR       = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic [WIDTH-1:0]      Rx_Data,
  input  logic                  Rx_Data_valid,
  input  logic                  Tx_Busy,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic                  WrEn,
  output logic [WIDTH-1:0]      WrData,
  output logic                  RdEn,
  output logic                  ALU_EN,
  output logic [ALU_FUN_W-1:0]  ALU_FUN,
  output logic                  CLK_GATE_EN
);

  if (TIMEOUT_CYCLES < 2) begin : gBadTimeout
    $error("sys_cntr_rx: TIMEOUT_CYCLES must be at least 2");
  end

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  latchAddr_q, latchAddr_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [WIDTH-1:0]       wrData_q, wrData_d;
  logic [ALU_FUN_W-1:0]   aluFun_q, aluFun_d;
  logic                   wrEn_q, wrEn_d;
  logic                   rdEn_q, rdEn_d;
  logic                   aluEn_q, aluEn_d;
  logic                   gate_q, gate_d;
  logic                   timeoutHit;

`ifdef SYS_RX_TIMEOUT_EN
  sys_rx_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) uTimeout (
    .clk_i    (CLK),
    .rst_ni   (Reset),
    .clear_i  (Rx_Data_valid),
    .active_i (waitsForByte(state_q)),
    .expired_o(timeoutHit)
  );
`else
  assign timeoutHit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    latchAddr_d = latchAddr_q;
    addr_d      = addr_q;
    wrData_d    = wrData_q;
    aluFun_d    = aluFun_q;
    wrEn_d      = 1'b0;
    rdEn_d      = 1'b0;
    aluEn_d     = 1'b0;
    // Gate stays open while an ALU op is pending and one cycle past ALU_EN.
    gate_d      = (state_q == ALU_FUN_S) || (state_q == ALU_ISSUE) || aluEn_q;

    case (state_q)
      IDLE: begin
        if (Rx_Data_valid) begin
          if (Rx_Data == WIDTH'(CMD_RF_WR))        state_d = WR_ADDR;
          else if (Rx_Data == WIDTH'(CMD_RF_RD))   state_d = RD_ADDR;
          else if (Rx_Data == WIDTH'(CMD_ALU_OP))  state_d = ALU_OPA;
          else if (Rx_Data == WIDTH'(CMD_ALU_NOP)) state_d = ALU_FUN_S;
        end
      end
      WR_ADDR: begin
        if (Rx_Data_valid) begin
          latchAddr_d = Rx_Data[ADDR_WIDTH-1:0];
          state_d     = WR_DATA;
        end else if (timeoutHit) begin
          state_d = IDLE;
        end
      end
      WR_DATA: begin
        if (Rx_Data_valid) begin
          wrEn_d   = 1'b1;
          addr_d   = latchAddr_q;
          wrData_d = Rx_Data;
          state_d  = IDLE;
        end else if (timeoutHit) begin
          state_d = IDLE;
        end
      end
      RD_ADDR: begin
        if (Rx_Data_valid) begin
          latchAddr_d = Rx_Data[ADDR_WIDTH-1:0];
          state_d     = RD_ISSUE;
        end else if (timeoutHit) begin
          state_d = IDLE;
        end
      end
      RD_ISSUE: begin
        if (!Tx_Busy) begin
          rdEn_d  = 1'b1;
          addr_d  = latchAddr_q;
          state_d = IDLE;
        end
      end
      ALU_OPA: begin
        if (Rx_Data_valid) begin
          wrEn_d   = 1'b1;
          addr_d   = ADDR_WIDTH'(OPA_ADDR);
          wrData_d = Rx_Data;
          state_d  = ALU_OPB;
        end else if (timeoutHit) begin
          state_d = IDLE;
        end
      end
      ALU_OPB: begin
        if (Rx_Data_valid) begin
          wrEn_d   = 1'b1;
          addr_d   = ADDR_WIDTH'(OPB_ADDR);
          wrData_d = Rx_Data;
          state_d  = ALU_FUN_S;
        end else if (timeoutHit) begin
          state_d = IDLE;
        end
      end
      ALU_FUN_S: begin
        if (Rx_Data_valid) begin
          aluFun_d = Rx_Data[ALU_FUN_W-1:0];
          state_d  = ALU_ISSUE;
        end else if (timeoutHit) begin
          state_d = IDLE;
        end
      end
      ALU_ISSUE: begin
        if (!Tx_Busy) begin
          aluEn_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        gate_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      latchAddr_q <= '0;
      addr_q      <= '0;
      wrData_q    <= '0;
      aluFun_q    <= '0;
      wrEn_q      <= 1'b0;
      rdEn_q      <= 1'b0;
      aluEn_q     <= 1'b0;
      gate_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      latchAddr_q <= latchAddr_d;
      addr_q      <= addr_d;
      wrData_q    <= wrData_d;
      aluFun_q    <= aluFun_d;
      wrEn_q      <= wrEn_d;
      rdEn_q      <= rdEn_d;
      aluEn_q     <= aluEn_d;
      gate_q      <= gate_d;
    end
  end

  assign Address     = addr_q;
  assign WrEn        = wrEn_q;
  assign WrData      = wrData_q;
  assign RdEn        = rdEn_q;
  assign ALU_EN      = aluEn_q;
  assign ALU_FUN     = aluFun_q;
  assign CLK_GATE_EN = gate_q;

endmodule

// File: tb/tb_sys_cntr_rx.sv
// Directed bench for sys_cntr_rx: a table of per-cycle vectors followed by
// hand-written read, reset and (with SYS_RX_TIMEOUT_EN) timeout sequences.
module tb_sys_cntr_rx;

`ifdef SYS_RX_TIMEOUT_EN
  localparam int TB_TIMEOUT = 16;
`else
  localparam int TB_TIMEOUT = 1024;
`endif

  logic       CLK;
  logic       Reset;
  logic [7:0] Rx_Data;
  logic       Rx_Data_valid;
  logic       Tx_Busy;
  logic [3:0] Address;
  logic       WrEn;
  logic [7:0] WrData;
  logic       RdEn;
  logic       ALU_EN;
  logic [3:0] ALU_FUN;
  logic       CLK_GATE_EN;

  int total = 0;
  int bad   = 0;

  sys_cntr_rx #(
    .TIMEOUT_CYCLES(TB_TIMEOUT)
  ) dut (
    .CLK          (CLK),
    .Reset        (Reset),
    .Rx_Data      (Rx_Data),
    .Rx_Data_valid(Rx_Data_valid),
    .Tx_Busy      (Tx_Busy),
    .Address      (Address),
    .WrEn         (WrEn),
    .WrData       (WrData),
    .RdEn         (RdEn),
    .ALU_EN       (ALU_EN),
    .ALU_FUN      (ALU_FUN),
    .CLK_GATE_EN  (CLK_GATE_EN)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       b;
    logic       we;
    logic       re;
    logic       ae;
    logic [3:0] addr;
    logic [7:0] wd;
    logic [3:0] fun;
    logic       gate;
  } vec_t;

  vec_t vecs [19];

  // Drive one cycle of inputs on the falling edge, then settle past the rising edge.
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic b);
    @(negedge CLK);
    Rx_Data_valid = v;
    Rx_Data       = d;
    Tx_Busy       = b;
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic we, input logic re,
                             input logic ae, input logic [3:0] addr,
                             input logic [7:0] wd, input logic [3:0] fun,
                             input logic gate);
    logic [19:0] act, exp;
    act = {WrEn, RdEn, ALU_EN, Address, WrData, ALU_FUN, CLK_GATE_EN};
    exp = {we, re, ae, addr, wd, fun, gate};
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got we=%b re=%b ae=%b addr=%h wd=%h fun=%h gate=%b, want we=%b re=%b ae=%b addr=%h wd=%h fun=%h gate=%b",
               name, WrEn, RdEn, ALU_EN, Address, WrData, ALU_FUN, CLK_GATE_EN,
               we, re, ae, addr, wd, fun, gate);
    end
  endtask

  initial begin
    // Fields: v, d, busy | we, re, ae, addr, wd, fun, gate (after the sampling edge)
    vecs = '{
      '{1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 4'h0, 1'b0},
      '{1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 4'h0, 1'b0},
      '{1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 4'h5, 8'h3C, 4'h0, 1'b0},
      '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'h5, 8'h3C, 4'h0, 1'b0},
      '{1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 4'h5, 8'h3C, 4'h0, 1'b0},
      '{1'b1, 8'hDD, 1'b0, 1'b0, 1'b0, 1'b0, 4'h5, 8'h3C, 4'h0, 1'b0},
      '{1'b1, 8'h0C, 1'b0, 1'b0, 1'b0, 1'b0, 4'h5, 8'h3C, 4'hC, 1'b1},
      '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 4'h5, 8'h3C, 4'hC, 1'b1},
      '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'h5, 8'h3C, 4'hC, 1'b1},
      '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'h5, 8'h3C, 4'hC, 1'b0},
      '{1'b1, 8'hCC, 1'b0, 1'b0, 1'b0, 1'b0, 4'h5, 8'h3C, 4'hC, 1'b0},
      '{1'b1, 8'h0A, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 8'h0A, 4'hC, 1'b0},
      '{1'b1, 8'h03, 1'b0, 1'b1, 1'b0, 1'b0, 4'h1, 8'h03, 4'hC, 1'b0},
      '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 8'h03, 4'h1, 1'b1},
      '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 4'h1, 8'h03, 4'h1, 1'b1},
      '{1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, 4'h1, 8'h03, 4'h1, 1'b1},
      '{1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 8'h03, 4'h1, 1'b1},
      '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 8'h03, 4'h1, 1'b0},
      '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 8'h03, 4'h1, 1'b0}
    };

    Reset         = 1'b0;
    Rx_Data       = 8'h00;
    Rx_Data_valid = 1'b0;
    Tx_Busy       = 1'b0;
    #12;
    checkOutput("reset_state", 0, 0, 0, 4'h0, 8'h00, 4'h0, 0);
    @(negedge CLK);
    Reset = 1'b1;

    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i].v, vecs[i].d, vecs[i].b);
      checkOutput($sformatf("vec%0d", i), vecs[i].we, vecs[i].re, vecs[i].ae,
                  vecs[i].addr, vecs[i].wd, vecs[i].fun, vecs[i].gate);
    end

    // Read held off by a busy transmit path; byte arriving as busy falls is dropped.
    applyStimulus(1, 8'hBB, 1);
    checkOutput("rd_cmd", 0, 0, 0, 4'h1, 8'h03, 4'h1, 0);
    applyStimulus(1, 8'h07, 1);
    checkOutput("rd_addr", 0, 0, 0, 4'h1, 8'h03, 4'h1, 0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 8'h00, 1);
      checkOutput($sformatf("rd_busy%0d", i), 0, 0, 0, 4'h1, 8'h03, 4'h1, 0);
    end
    applyStimulus(1, 8'hAA, 0);
    checkOutput("rd_issue", 0, 1, 0, 4'h7, 8'h03, 4'h1, 0);
    applyStimulus(1, 8'h05, 0);
    checkOutput("rd_drop_a", 0, 0, 0, 4'h7, 8'h03, 4'h1, 0);
    applyStimulus(1, 8'h3C, 0);
    checkOutput("rd_drop_b", 0, 0, 0, 4'h7, 8'h03, 4'h1, 0);

    // Reset in the middle of a write frame.
    applyStimulus(1, 8'hAA, 0);
    applyStimulus(1, 8'h05, 0);
    checkOutput("mid_frame", 0, 0, 0, 4'h7, 8'h03, 4'h1, 0);
    @(negedge CLK);
    Rx_Data_valid = 1'b0;
    Reset         = 1'b0;
    #2;
    checkOutput("mid_reset", 0, 0, 0, 4'h0, 8'h00, 4'h0, 0);
    @(negedge CLK);
    Reset = 1'b1;
    applyStimulus(1, 8'h3C, 0);
    checkOutput("post_reset_3c", 0, 0, 0, 4'h0, 8'h00, 4'h0, 0);
    applyStimulus(0, 8'h00, 0);
    checkOutput("post_reset_idle", 0, 0, 0, 4'h0, 8'h00, 4'h0, 0);
    applyStimulus(1, 8'hAA, 0);
    applyStimulus(1, 8'h03, 0);
    applyStimulus(1, 8'h99, 0);
    checkOutput("post_reset_wr", 1, 0, 0, 4'h3, 8'h99, 4'h0, 0);

`ifdef SYS_RX_TIMEOUT_EN
    // Stalled write frame times out; the following read frame is decoded fresh.
    applyStimulus(1, 8'hAA, 0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 8'h00, 0);
    end
    checkOutput("to_idle", 0, 0, 0, 4'h3, 8'h99, 4'h0, 0);
    applyStimulus(1, 8'hBB, 0);
    applyStimulus(1, 8'h02, 0);
    checkOutput("to_no_wr", 0, 0, 0, 4'h3, 8'h99, 4'h0, 0);
    applyStimulus(0, 8'h00, 0);
    checkOutput("to_rd", 0, 1, 0, 4'h2, 8'h99, 4'h0, 0);
`endif

    applyStimulus(0, 8'h00, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sys_cntr_rx.md
Name: sys_cntr_rx

Overview:
- Receive-side system controller: parses command frames arriving as bytes from the UART receiver (already synchronised into the CLK domain).
- Drives register-file writes and reads, ALU operand loading and ALU execution, plus the ALU clock-gate enable.
- Sits upstream of the register file and ALU, whose outputs feed the transmit-side controller.
- Holds off issuing reads and ALU operations while the transmit path is busy, so no result is lost.

Parameters:
WIDTH, 8, data/byte width
ADDR_WIDTH, 4, register-file address width
OPA_ADDR, 0, register-file address of ALU operand A
OPB_ADDR, 1, register-file address of ALU operand B
TIMEOUT_CYCLES, 1024, inter-byte timeout in CLK cycles (used only with SYS_RX_TIMEOUT_EN)

Ports:
CLK  in  1  system clock
Reset  in  1  asynchronous active-low reset
Rx_Data  in  WIDTH  received byte
Rx_Data_valid  in  1  single-cycle pulse, Rx_Data valid
Tx_Busy  in  1  transmit path busy (UART busy or transmit controller mid-transfer)
Address  out  ADDR_WIDTH  register-file address
WrEn  out  1  register-file write strobe, one cycle
WrData  out  WIDTH  register-file write data
RdEn  out  1  register-file read strobe, one cycle
ALU_EN  out  1  ALU execute strobe, one cycle
ALU_FUN  out  4  ALU function; held until the next ALU command
CLK_GATE_EN  out  1  ALU clock-gate enable

Behaviour:
- Single clock CLK; reset is asynchronous, active-low on Reset.
- All outputs are registered and reset to 0; the FSM resets to IDLE.
- Command codes:
  - 0xAA = RF write: addr, data
  - 0xBB = RF read: addr
  - 0xCC = ALU with operands: A, B, FUN
  - 0xDD = ALU without operands: FUN
- Addresses are taken from Rx_Data[ADDR_WIDTH-1:0]; the upper bits are ignored.
- A byte is accepted in the cycle Rx_Data_valid=1. Resulting strobes assert in the next cycle, for exactly one cycle.
- FSM states and transitions:
  - IDLE: on a byte, 0xAA->WR_ADDR, 0xBB->RD_ADDR, 0xCC->ALU_OPA, 0xDD->ALU_FUN_S. Any other byte is discarded; stay in IDLE.
  - WR_ADDR: latch addr -> WR_DATA.
  - WR_DATA: byte -> WrEn=1, Address=latched addr, WrData=byte -> IDLE.
  - RD_ADDR: latch addr -> RD_ISSUE.
  - RD_ISSUE: when Tx_Busy=0, RdEn=1 with Address -> IDLE; otherwise wait.
  - ALU_OPA: byte -> WrEn=1, Address=OPA_ADDR -> ALU_OPB.
  - ALU_OPB: byte -> WrEn=1, Address=OPB_ADDR -> ALU_FUN_S.
  - ALU_FUN_S: latch byte[3:0] into ALU_FUN -> ALU_ISSUE.
  - ALU_ISSUE: when Tx_Busy=0, ALU_EN=1 -> IDLE; otherwise wait.
- CLK_GATE_EN is 1 from the cycle after entering ALU_FUN_S through the ALU_EN cycle plus one cycle, then 0. This lets the gated ALU register its result.
- ALU_FUN is never cleared except by reset; the transmit side decodes it after ALU_EN.
- Address and WrData hold their last value between strobes.
- Bytes arriving in RD_ISSUE or ALU_ISSUE are dropped.
- Tx_Busy is sampled only in the ISSUE states. Tx_Busy falling in the same cycle a byte arrives: the strobe is issued and the byte is dropped.
- Reset mid-frame: immediate return to IDLE, strobes deasserted; the partial frame is lost.
- Unreachable state encodings -> IDLE with all strobes 0.

Optional Feature:
- Macro: SYS_RX_TIMEOUT_EN.
- Defined:
  - A counter clears on every accepted byte and increments while in a state that waits for a byte (WR_ADDR, WR_DATA, RD_ADDR, ALU_OPA, ALU_OPB, ALU_FUN_S).
  - Reaching TIMEOUT_CYCLES-1 returns the FSM to IDLE with no strobe.
  - Operand writes already issued remain in the register file.
  - The counter is not active in the ISSUE states.
- Undefined: no counter; the FSM waits indefinitely for the next byte.

Decomposition:
- Package sys_pkg: command code constants (CMD_RF_WR, CMD_RF_RD, CMD_ALU_OP, CMD_ALU_NOP), FSM state enum, ALU_FUN width constant.
- One natural sub-module: sys_rx_timeout (counter plus expiry compare), instantiated only under SYS_RX_TIMEOUT_EN.

Test Plan:
- RF write: bytes AA,05,3C -> one cycle after the 3C byte, WrEn=1, Address=5, WrData=0x3C; FSM back to IDLE.
- RF read under busy: BB,07 with Tx_Busy=1 for 20 cycles -> RdEn stays 0; RdEn=1 with Address=7 one cycle after Tx_Busy falls.
- ALU command: CC,0A,03,01:
  - WrEn to addr 0 with 0x0A, then WrEn to addr 1 with 0x03.
  - ALU_FUN=1; ALU_EN pulses once.
  - CLK_GATE_EN high from after FUN through ALU_EN+1, then low; ALU_FUN stays 1 afterwards.
- No-operand ALU, stray bytes: 55 then DD,0C -> 0x55 ignored; ALU_EN with ALU_FUN=0xC; no WrEn.
- Reset mid-frame: AA,05, assert Reset, release, send 3C -> no WrEn; 0x3C treated as an unknown command.
- Timeout (SYS_RX_TIMEOUT_EN defined, TIMEOUT_CYCLES=16): AA then 20 idle cycles, then BB,02 -> RdEn with Address=2 and no WrEn.
